// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions.
// Contents: base opcode constants, immediate-format enum and the decoded-instruction
// struct passed from decode_comb to the buffered decode stage.
package riscv_pkg;

  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;

  // FmtR doubles as "no immediate" (OP and unknown opcodes).
  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} imm_fmt_e;

  // imm carries the 32-bit immediate; bit 31 is the sign for widening to XLEN.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  alu_func;
    logic [31:0] imm;
    logic        illegal;
  } dec_inst_t;

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV32I(E) instruction decoder.
// Ports:
//   inst_i : raw 32-bit instruction
//   dec_o  : decoded fields; all zero except illegal when the instruction is illegal
module decode_comb
  import riscv_pkg::*;
#(
  parameter bit RV32E = 1'b0
) (
  input  logic [31:0] inst_i,
  output dec_inst_t   dec_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  imm_fmt_e    fmt;
  logic        known, has_f3, use_rs1, use_rs2, use_rd;
  logic        is_shift_imm, op_bad, e_bad, illegal;
  logic [31:0] imm;
  logic [3:0]  alu_func;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    fmt     = FmtR;
    known   = 1'b1;
    has_f3  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OpcLui, OpcAuipc: begin fmt = FmtU; use_rd = 1'b1; end
      OpcJal:    begin fmt = FmtJ; use_rd = 1'b1; end
      OpcJalr,
      OpcLoad,
      OpcOpImm:  begin fmt = FmtI; has_f3 = 1'b1; use_rs1 = 1'b1; use_rd = 1'b1; end
      OpcBranch: begin fmt = FmtB; has_f3 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpcStore:  begin fmt = FmtS; has_f3 = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OpcOp: begin
        fmt     = FmtR;
        has_f3  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      default: known = 1'b0;
    endcase
  end

  assign is_shift_imm = (opcode == OpcOpImm) && (funct3[1:0] == 2'b01);

  always_comb begin
    imm = '0;
    unique case (fmt)
      FmtI: imm = {{20{inst_i[31]}}, inst_i[31:20]};
      FmtS: imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      FmtB: imm = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
      FmtU: imm = {inst_i[31:12], 12'b0};
      FmtJ: imm = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
      default: imm = '0;
    endcase
    // Shift-immediates carry a shamt, not a signed immediate.
    if (is_shift_imm) imm = {27'b0, inst_i[24:20]};
  end

  always_comb begin
    alu_func = '0;
    if ((opcode == OpcOp) || is_shift_imm) alu_func = {inst_i[30], funct3};
    else if (has_f3)                        alu_func = {1'b0, funct3};
  end

  // OP accepts funct7 0000000 always, 0100000 only for SUB and SRA.
  assign op_bad = (opcode == OpcOp) &&
                  !((funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));

  assign e_bad = RV32E && ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) ||
                           (use_rd && inst_i[11]));

  assign illegal = (inst_i[1:0] != 2'b11) || !known || op_bad || e_bad;

  always_comb begin
    dec_o         = '0;
    dec_o.illegal = illegal;
    if (!illegal) begin
      dec_o.opcode   = opcode;
      dec_o.rs1      = use_rs1 ? inst_i[19:15] : 5'd0;
      dec_o.rs2      = use_rs2 ? inst_i[24:20] : 5'd0;
      dec_o.rd       = use_rd  ? inst_i[11:7]  : 5'd0;
      dec_o.alu_func = alu_func;
      dec_o.imm      = imm;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Buffered decode stage: decodes each accepted instruction and holds it in a
// 2-entry in-order buffer (head, skid) with ready/valid on both sides.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop all buffered entries (and any same-cycle accept)
//   inst_valid/ready    : upstream handshake, inst + pc payload
//   dec_valid/ready     : downstream handshake
//   dec_*               : decoded fields of the head entry
module decode_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter bit          RV32E = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [6:0]      dec_opcode,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [4:0]      dec_rd,
  output logic [3:0]      dec_alu_func,
  output logic [XLEN-1:0] dec_imm,
  output logic [XLEN-1:0] dec_pc,
  output logic            dec_illegal
);

  dec_inst_t       new_dec;
  dec_inst_t       head_q, head_d, skid_q, skid_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, skid_pc_q, skid_pc_d;
  logic [1:0]      count_q, count_d;
  logic            accept, deliver;

  decode_comb #(
    .RV32E(RV32E)
  ) u_decode_comb (
    .inst_i(inst),
    .dec_o (new_dec)
  );

  assign inst_ready = (count_q != 2'd2);
  assign dec_valid  = (count_q != 2'd0);
  assign accept     = inst_valid && inst_ready;
  assign deliver    = dec_valid && dec_ready;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    head_pc_d = head_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (accept) begin
            head_d    = new_dec;
            head_pc_d = pc;
            count_d   = 2'd1;
          end
        end
        2'd1: begin
          if (accept && deliver) begin
            head_d    = new_dec;
            head_pc_d = pc;
          end else if (accept) begin
            skid_d    = new_dec;
            skid_pc_d = pc;
            count_d   = 2'd2;
          end else if (deliver) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          // inst_ready is low here, so only a deliver can occur.
          if (deliver) begin
            head_d    = skid_q;
            head_pc_d = skid_pc_q;
            count_d   = 2'd1;
          end
        end
        default: count_d = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      head_pc_q <= '0;
      skid_q    <= '0;
      skid_pc_q <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      head_pc_q <= head_pc_d;
      skid_q    <= skid_d;
      skid_pc_q <= skid_pc_d;
    end
  end

  assign dec_opcode   = head_q.opcode;
  assign dec_rs1      = head_q.rs1;
  assign dec_rs2      = head_q.rs2;
  assign dec_rd       = head_q.rd;
  assign dec_alu_func = head_q.alu_func;
  assign dec_imm      = XLEN'($signed(head_q.imm));
  assign dec_pc       = head_pc_q;
  assign dec_illegal  = head_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: an RV32I instance and an RV32E instance
// share all stimulus; a queue model predicts handshake and decoded outputs.
module tb_decode_stage;

  logic        clk, rst, flush, inst_valid, dec_ready;
  logic [31:0] inst, pc;

  logic        inst_ready0, dec_valid0, dec_ill0;
  logic [6:0]  dec_opcode0;
  logic [4:0]  dec_rs1_0, dec_rs2_0, dec_rd0;
  logic [3:0]  dec_alu0;
  logic [31:0] dec_imm0, dec_pc0;

  logic        inst_ready1, dec_valid1, dec_ill1;
  logic [6:0]  dec_opcode1;
  logic [4:0]  dec_rs1_1, dec_rs2_1, dec_rd1;
  logic [3:0]  dec_alu1;
  logic [31:0] dec_imm1, dec_pc1;

  decode_stage #(.XLEN(32), .RV32E(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready0), .inst(inst), .pc(pc),
    .dec_valid(dec_valid0), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode0), .dec_rs1(dec_rs1_0), .dec_rs2(dec_rs2_0), .dec_rd(dec_rd0),
    .dec_alu_func(dec_alu0), .dec_imm(dec_imm0), .dec_pc(dec_pc0), .dec_illegal(dec_ill0)
  );

  decode_stage #(.XLEN(32), .RV32E(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_valid(inst_valid), .inst_ready(inst_ready1), .inst(inst), .pc(pc),
    .dec_valid(dec_valid1), .dec_ready(dec_ready),
    .dec_opcode(dec_opcode1), .dec_rs1(dec_rs1_1), .dec_rs2(dec_rs2_1), .dec_rd(dec_rd1),
    .dec_alu_func(dec_alu1), .dec_imm(dec_imm1), .dec_pc(dec_pc1), .dec_illegal(dec_ill1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];

  // Literal expectations set by the stimulus process, checked at the next negedge.
  logic        lit_en = 1'b0;
  logic        lit_sel;
  logic        lit_valid, lit_ready;
  logic [90:0] lit_fields;

  // Packed view: {opcode, rs1, rs2, rd, alu_func, imm, pc, illegal}.
  function automatic logic [90:0] pack(input logic [6:0] op, input logic [4:0] r1,
                                       input logic [4:0] r2, input logic [4:0] rd,
                                       input logic [3:0] alu, input logic [31:0] imm,
                                       input logic [31:0] p, input logic ill);
    return {op, r1, r2, rd, alu, imm, p, ill};
  endfunction

  // Reference decode written straight from the instruction-set rules.
  function automatic logic [90:0] ref_decode(input logic [31:0] in, input logic [31:0] p,
                                             input bit e);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [3:0]  alu;
    bit          r1, r2, rdu, bad;
    op = in[6:0]; f3 = in[14:12]; f7 = in[31:25];
    imm = 0; alu = 0; r1 = 0; r2 = 0; rdu = 0; bad = 0;
    case (op)
      7'h37, 7'h17: begin imm = {in[31:12], 12'h000}; rdu = 1; end
      7'h6f: begin
        imm = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0}; rdu = 1;
      end
      7'h67, 7'h03: begin
        imm = {{20{in[31]}}, in[31:20]}; alu = {1'b0, f3}; r1 = 1; rdu = 1;
      end
      7'h13: begin
        r1 = 1; rdu = 1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          imm = {27'd0, in[24:20]}; alu = {in[30], f3};
        end else begin
          imm = {{20{in[31]}}, in[31:20]}; alu = {1'b0, f3};
        end
      end
      7'h63: begin
        imm = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        alu = {1'b0, f3}; r1 = 1; r2 = 1;
      end
      7'h23: begin
        imm = {{20{in[31]}}, in[31:25], in[11:7]}; alu = {1'b0, f3}; r1 = 1; r2 = 1;
      end
      7'h33: begin
        alu = {in[30], f3}; r1 = 1; r2 = 1; rdu = 1;
        bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      default: bad = 1;
    endcase
    if (in[1:0] != 2'b11) bad = 1;
    if (e && ((r1 && in[19:15] > 15) || (r2 && in[24:20] > 15) || (rdu && in[11:7] > 15)))
      bad = 1;
    if (bad) return pack(7'd0, 5'd0, 5'd0, 5'd0, 4'd0, 32'd0, p, 1'b1);
    return pack(op, r1 ? in[19:15] : 5'd0, r2 ? in[24:20] : 5'd0, rdu ? in[11:7] : 5'd0,
                alu, imm, p, 1'b0);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Model: in-order queue of at most two entries.
  bit m_acc, m_del;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      m_acc = inst_valid && (mq.size() != 2);
      m_del = dec_ready && (mq.size() != 0);
      if (flush) begin
        mq.delete();
      end else begin
        if (m_del) void'(mq.pop_front());
        if (m_acc) mq.push_back('{inst: inst, pc: pc});
      end
    end
  end

  logic [90:0] act0, act1;
  assign act0 = {dec_opcode0, dec_rs1_0, dec_rs2_0, dec_rd0, dec_alu0, dec_imm0, dec_pc0,
                 dec_ill0};
  assign act1 = {dec_opcode1, dec_rs1_1, dec_rs2_1, dec_rd1, dec_alu1, dec_imm1, dec_pc1,
                 dec_ill1};

  // Single compare process.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst inst_ready0", inst_ready0, 1'b1);
      chk("rst dec_valid0", dec_valid0, 1'b0);
      chk("rst fields0", act0, 91'd0);
      chk("rst inst_ready1", inst_ready1, 1'b1);
      chk("rst dec_valid1", dec_valid1, 1'b0);
      chk("rst fields1", act1, 91'd0);
    end else begin
      chk("inst_ready0", inst_ready0, mq.size() != 2);
      chk("dec_valid0", dec_valid0, mq.size() != 0);
      chk("inst_ready1", inst_ready1, mq.size() != 2);
      chk("dec_valid1", dec_valid1, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("fields rv32i", act0, ref_decode(mq[0].inst, mq[0].pc, 1'b0));
        chk("fields rv32e", act1, ref_decode(mq[0].inst, mq[0].pc, 1'b1));
      end
    end
    if (lit_en) begin
      chk("lit dec_valid", lit_sel ? dec_valid1 : dec_valid0, lit_valid);
      chk("lit inst_ready", lit_sel ? inst_ready1 : inst_ready0, lit_ready);
      if (lit_valid) chk("lit fields", lit_sel ? act1 : act0, lit_fields);
    end
  end

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic r, input logic f);
    inst_valid = v; inst = i; pc = p; dec_ready = r; flush = f;
  endtask

  task automatic expect_lit(input logic sel, input logic v, input logic rdy,
                            input logic [90:0] fields);
    lit_sel = sel; lit_valid = v; lit_ready = rdy; lit_fields = fields; lit_en = 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    int k;
    r = $urandom();
    k = $urandom_range(0, 11);
    case (k)
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6f;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h03;
      6: r[6:0] = 7'h23;
      7: r[6:0] = 7'h13;
      8: begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      9: r[6:0] = 7'h33;
      10: r[6:0] = 7'h0f;
      default: ;
    endcase
    return r;
  endfunction

  localparam logic [31:0] InstA = 32'h00A00513;  // addi x10,x0,10
  localparam logic [31:0] InstB = 32'h00B00593;  // addi x11,x0,11
  localparam logic [31:0] InstC = 32'h00C00613;  // addi x12,x0,12

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    // ADDI x1,x0,-1 from empty: visible one cycle after acceptance.
    drive(1'b1, 32'hFFF00093, 32'h100, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b1, pack(7'h13, 5'd0, 5'd0, 5'd1, 4'h0, 32'hFFFFFFFF, 32'h100, 1'b0));
    tick();
    // JAL x0,-4 while ADDI delivers.
    drive(1'b1, 32'hFFDFF06F, 32'h104, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b1, pack(7'h6F, 5'd0, 5'd0, 5'd0, 4'h0, 32'hFFFFFFFC, 32'h104, 1'b0));
    tick();
    // SRAI x2,x2,3.
    drive(1'b1, 32'h40315113, 32'h108, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b1, pack(7'h13, 5'd2, 5'd0, 5'd2, 4'b1101, 32'd3, 32'h108, 1'b0));
    tick();
    // ADD x16,x0,x0 on the RV32E instance: illegal, only pc kept.
    drive(1'b1, 32'h00000833, 32'h10C, 1'b1, 1'b0);
    expect_lit(1'b1, 1'b1, 1'b1, pack(7'h0, 5'd0, 5'd0, 5'd0, 4'h0, 32'd0, 32'h10C, 1'b1));
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();

    // Back-pressure: three offered, two accepted, then ordered drain.
    drive(1'b1, InstA, 32'h200, 1'b0, 1'b0);
    tick();
    drive(1'b1, InstB, 32'h204, 1'b0, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b0, pack(7'h13, 5'd0, 5'd0, 5'd10, 4'h0, 32'd10, 32'h200, 1'b0));
    tick();
    drive(1'b1, InstC, 32'h208, 1'b0, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b0, pack(7'h13, 5'd0, 5'd0, 5'd10, 4'h0, 32'd10, 32'h200, 1'b0));
    tick();
    drive(1'b1, InstC, 32'h208, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b1, pack(7'h13, 5'd0, 5'd0, 5'd11, 4'h0, 32'd11, 32'h204, 1'b0));
    tick();
    drive(1'b1, InstC, 32'h208, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b1, 1'b1, pack(7'h13, 5'd0, 5'd0, 5'd12, 4'h0, 32'd12, 32'h208, 1'b0));
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b0, 1'b1, 91'd0);
    tick();

    // Flush at count 2, with a same-cycle offer that must be dropped.
    drive(1'b1, InstA, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b1, InstB, 32'h304, 1'b0, 1'b0);
    tick();
    drive(1'b1, InstC, 32'h308, 1'b1, 1'b1);
    expect_lit(1'b0, 1'b0, 1'b1, 91'd0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b0, 1'b1, 91'd0);
    tick();

    // Asynchronous reset mid-operation, between clock edges.
    drive(1'b1, InstA, 32'h400, 1'b0, 1'b0);
    tick();
    drive(1'b1, InstB, 32'h404, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    expect_lit(1'b0, 1'b0, 1'b1, 91'd0);
    tick();
    expect_lit(1'b1, 1'b0, 1'b1, 91'd0);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, gen_inst(), $urandom() & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
      tick();
    end

    drive(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
